hex_scan_driver: RTL and testbench
==================================

HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 Parameter DIV, default 100000, clock cycles per digit slot (1 kHz/digit at 100 MHz); legal range DIV >= 2.
REQ-002 Parameter GUARD, default 1000, cycles at slot start with all anodes off (anti-ghosting); legal range 0 <= GUARD < DIV.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  16  four hex digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-006 dp_in  input  4  decimal-point request per digit, active-high, bit i = digit i.
REQ-007 load  input  1  single-cycle strobe capturing data_in/dp_in into the shadow register.
REQ-008 lz_blank  input  1  enables leading-zero blanking, level-sensitive.
REQ-009 an  output  4  digit anode enables, active-low, bit i = digit i.
REQ-010 seg  output  7  segments {a,b,c,d,e,f,g}, active-low, hex glyph encoding 0-F per the team decoder.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 frame_done  output  1  one-cycle pulse when the active register is updated.

Function
REQ-013 Slot counter SHALL count 0..DIV-1 and wrap to 0; digit index idx SHALL advance 0->1->2->3->0 on each wrap.
REQ-014 Frame boundary = cycle where slot counter = DIV-1 and idx = 3.
REQ-015 load SHALL write data_in/dp_in into shadow on the same edge, regardless of scan position.
REQ-016 At each frame boundary, active <= shadow and frame_done SHALL pulse high for exactly one cycle on the following cycle.
REQ-017 load coincident with a frame boundary SHALL bypass: active receives data_in/dp_in directly on that edge.
REQ-018 Displayed value SHALL change only at frame boundaries (no intra-frame tearing).
REQ-019 While slot counter < GUARD: an = 4'b1111, seg = 7'b1111111, dp = 1.
REQ-020 Otherwise: an = ~(4'b0001 << idx), seg = glyph(active nibble idx), dp = ~active_dp[idx].
REQ-021 Leading-zero blanking (lz_blank=1): digit 3 blanked if nibble3 = 0; digit 2 if nibbles 3,2 = 0; digit 1 if nibbles 3,2,1 = 0; digit 0 never blanked.
REQ-022 Blanked digit: an bit stays 1, seg = 7'b1111111, dp = 1 even if dp requested.
REQ-023 an, seg, dp SHALL be registered and update together on one edge; latency one cycle from counter/idx state to pins.
REQ-024 GUARD = 0 SHALL disable the guard interval with no other effect.

Reset
REQ-025 reset asserted SHALL immediately force: slot counter 0, idx 0, shadow 0, active 0, active_dp 0, an 4'b1111, seg 7'b1111111, dp 1, frame_done 0.
REQ-026 Reset mid-frame SHALL abandon the frame; after release, scanning restarts at digit 0, slot count 0, displaying 0000.
REQ-027 load during reset SHALL be ignored.

Structure
REQ-028 Shared package SHALL hold NUM_DIGITS = 4, SEG_BLANK = 7'b1111111, AN_OFF = 4'b1111.
REQ-029 Glyph decode SHALL be the existing hex-to-7-segment decoder instantiated as the single sub-module hex2seg; no duplicate glyph table.
REQ-030 Implementation SHALL be synthesizable, single clock domain, no latches.

Verification (bench with DIV=8, GUARD=2)
REQ-031 Reset release, no load -> an cycles 1111,1111,1110x6, then 1111x2,1101x6 ...; seg = 7'b0000001 when enabled.
REQ-032 load data_in=16'h12AF, dp_in=4'b0100 mid-frame -> display unchanged until boundary; frame_done pulse; next frame digits F,A,2,1 with dp=0 only while an=1011.
REQ-033 load 16'h0005 with lz_blank=1 -> digits 3,2,1 keep an bit 1 and seg 1111111; digit 0 shows 7'b0100100; lz_blank=0 -> digits 3..1 show 7'b0000001.
REQ-034 load asserted exactly at frame boundary with 16'hBEEF -> next frame shows BEEF immediately (bypass), frame_done high one cycle.
REQ-035 reset pulsed while idx=2, slot count 5 -> outputs forced to blank same cycle asynchronously; restart at digit 0 showing 0.
REQ-036 GUARD=0 rerun of REQ-031 -> no all-off cycles; each anode low for all 8 cycles of its slot.

Source files
------------

// File: rtl/hex_scan_driver_pkg.sv
// Shared constants and helpers for the four-digit multiplexed hex display driver.
package hex_scan_driver_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    // True when digit idx is part of the run of leading zeros above the first non-zero nibble.
    function automatic logic leading_zero(input logic [15:0] val, input logic [1:0] idx);
        logic blank;
        case (idx)
            2'd3:    blank = (val[15:12] == 4'h0);
            2'd2:    blank = (val[15:8] == 8'h00);
            2'd1:    blank = (val[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/hex_scan_driver_hex2seg.sv
// Hex nibble to active-low {a,b,c,d,e,f,g} seven-segment glyph.
module hex2seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        unique case (hex_i)
            4'h0: seg_o = 7'b0000001;
            4'h1: seg_o = 7'b1001111;
            4'h2: seg_o = 7'b0010010;
            4'h3: seg_o = 7'b0000110;
            4'h4: seg_o = 7'b1001100;
            4'h5: seg_o = 7'b0100100;
            4'h6: seg_o = 7'b0100000;
            4'h7: seg_o = 7'b0001111;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0000100;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b1100000;
            4'hC: seg_o = 7'b0110001;
            4'hD: seg_o = 7'b1000010;
            4'hE: seg_o = 7'b0110000;
            4'hF: seg_o = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed four-digit hex display driver with shadow/active double buffering,
// per-slot anti-ghosting guard interval and optional leading-zero blanking.
module hex_scan_driver
    import hex_scan_driver_pkg::*;
#(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned GUARD = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     shadow_q, shadow_d, active_q, active_d;
    logic [3:0]      shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_done_q, frame_done_d;

    logic            slot_end, frame_end, in_guard, blanked;
    logic [3:0]      cur_nib;
    logic [6:0]      glyph;

    assign cur_nib = 4'(active_q >> {idx_q, 2'b00});

    hex2seg u_hex2seg (
        .hex_i (cur_nib),
        .seg_o (glyph)
    );

    always_comb begin
        slot_end  = (cnt_q == CntLast);
        frame_end = slot_end && (idx_q == 2'd3);
        // Written as cnt+1 <= GUARD so GUARD = 0 never forms a constant unsigned compare.
        in_guard  = (32'(cnt_q) + 32'd1) <= GUARD;
        blanked   = lz_blank && leading_zero(active_q, idx_q);

        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
        idx_d        = slot_end ? idx_q + 2'd1 : idx_q;
        shadow_d     = load ? data_in : shadow_q;
        shadow_dp_d  = load ? dp_in : shadow_dp_q;
        active_d     = active_q;
        active_dp_d  = active_dp_q;
        frame_done_d = frame_end;

        // A load on the boundary edge goes straight to active so it is not a frame late.
        if (frame_end) begin
            active_d    = load ? data_in : shadow_q;
            active_dp_d = load ? dp_in : shadow_dp_q;
        end

        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!in_guard && !blanked) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = glyph;
            dp_d  = ~active_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver: frame-level model checked every cycle plus directed literal checks.
module tb_hex_scan_driver;

    localparam int unsigned DIV   = 8;
    localparam int unsigned GUARD = 2;
    localparam int          FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [3:0]  an, an0;
    logic [6:0]  seg, seg0;
    logic        dp, dp0, frame_done, frame_done0;

    int n_vec = 0;
    int n_bad = 0;

    hex_scan_driver #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    hex_scan_driver #(.DIV(DIV), .GUARD(0)) dut_g0 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .an         (an0),
        .seg        (seg0),
        .dp         (dp0),
        .frame_done (frame_done0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Lit segments (active-high abcdefg) for 0..F; pins are the complement.
    logic [6:0] lit [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Model: position within a frame, shadow/active buffers, expected pins after each edge.
    int          pos = 0;
    logic [15:0] m_shadow = '0, m_active = '0;
    logic [3:0]  m_sdp = '0, m_adp = '0;
    logic [3:0]  e_an = 4'hF, e_an0 = 4'hF;
    logic [6:0]  e_seg = 7'h7F, e_seg0 = 7'h7F;
    logic        e_dp = 1'b1, e_dp0 = 1'b1, e_fd = 1'b0;

    task automatic pins(input int slot, input int idx, input int guard,
                        output logic [3:0] a, output logic [6:0] s, output logic d);
        int hi = 0;
        logic [3:0] nib;
        for (int i = 0; i < 4; i++) if (((m_active >> (4 * i)) & 16'hF) != 0) hi = i;
        nib = 4'((m_active >> (4 * idx)) & 16'hF);
        if (slot < guard || (lz_blank && idx > hi)) begin
            a = 4'hF; s = 7'h7F; d = 1'b1;
        end else begin
            a = ~(4'b0001 << idx); s = ~lit[nib]; d = ~m_adp[idx];
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pos = 0; m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0;
            e_an = 4'hF; e_an0 = 4'hF; e_seg = 7'h7F; e_seg0 = 7'h7F;
            e_dp = 1'b1; e_dp0 = 1'b1; e_fd = 1'b0;
        end else begin
            pins(pos % DIV, pos / DIV, GUARD, e_an, e_seg, e_dp);
            pins(pos % DIV, pos / DIV, 0, e_an0, e_seg0, e_dp0);
            e_fd = (pos == FRAME - 1);
            if (pos == FRAME - 1) begin
                m_active = load ? data_in : m_shadow;
                m_adp    = load ? dp_in : m_sdp;
            end
            if (load) begin
                m_shadow = data_in;
                m_sdp    = dp_in;
            end
            pos = (pos + 1) % FRAME;
        end
    end

    always @(negedge clk) begin
        check("an", 16'(an), 16'(e_an));
        check("seg", 16'(seg), 16'(e_seg));
        check("dp", 16'(dp), 16'(e_dp));
        check("frame_done", 16'(frame_done), 16'(e_fd));
        check("an_g0", 16'(an0), 16'(e_an0));
        check("seg_g0", 16'(seg0), 16'(e_seg0));
        check("dp_g0", 16'(dp0), 16'(e_dp0));
        check("frame_done_g0", 16'(frame_done0), 16'(e_fd));
    end

    logic [3:0] start_an [16] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
                                  4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};
    logic [3:0] start_an0 [16] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
                                   4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};

    // First two slots after reset release, showing zeros.
    task automatic check_startup();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("start_an", 16'(an), 16'(start_an[k]));
            check("start_an_g0", 16'(an0), 16'(start_an0[k]));
            if (an != 4'hF) check("start_seg", 16'(seg), 16'(7'b0000001));
        end
    endtask

    task automatic wait_fd(input string name);
        logic seen = 1'b0;
        for (int k = 0; k < FRAME + 4 && !seen; k++) begin
            @(negedge clk);
            seen = frame_done;
        end
        check(name, 16'(seen), 16'd1);
    endtask

    task automatic wait_an(input string name, input logic [3:0] want);
        logic seen = 1'b0;
        for (int k = 0; k < FRAME + 4 && !seen; k++) begin
            @(negedge clk);
            seen = (an == want);
        end
        check(name, 16'(seen), 16'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data_in = d; dp_in = p; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        logic       bad;
        logic [6:0] d0_seg;
        logic       seen;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_an", 16'(an), 16'hF);
        check("reset_seg", 16'(seg), 16'h7F);
        reset = 1'b0;
        check_startup();

        // Mid-frame load: held in shadow until the boundary.
        repeat (4) @(negedge clk);
        do_load(16'h12AF, 4'b0100);
        check("no_tear_seg", 16'(seg), 16'(7'b0000001));
        wait_fd("fd_12af");
        wait_an("see_d2", 4'b1011);
        check("d2_seg", 16'(seg), 16'(7'b0010010));
        check("d2_dp", 16'(dp), 16'd0);
        wait_an("see_d0", 4'b1110);
        check("d0_seg", 16'(seg), 16'(7'b0111000));
        check("d0_dp", 16'(dp), 16'd1);

        // Leading-zero blanking on 0005.
        lz_blank = 1'b1;
        do_load(16'h0005, 4'b1111);
        wait_fd("fd_0005");
        bad = 1'b0;
        d0_seg = 7'h7F;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (an[3:1] != 3'b111 || (an == 4'hF && (seg != 7'h7F || dp != 1'b1))) bad = 1'b1;
            if (an == 4'b1110) d0_seg = seg;
        end
        check("lz_upper_blank", 16'(bad), 16'd0);
        check("lz_d0_seg", 16'(d0_seg), 16'(7'b0100100));
        lz_blank = 1'b0;
        wait_an("see_d3", 4'b0111);
        check("d3_zero_seg", 16'(seg), 16'(7'b0000001));

        // Load exactly on the boundary edge bypasses the shadow.
        data_in = 16'h0; dp_in = 4'h0;
        wait_fd("fd_sync");
        repeat (FRAME - 1) @(negedge clk);
        do_load(16'hBEEF, 4'b0000);
        check("bypass_fd", 16'(frame_done), 16'd1);
        @(negedge clk);
        check("bypass_fd_low", 16'(frame_done), 16'd0);
        wait_an("see_b", 4'b0111);
        check("bypass_seg_b", 16'(seg), 16'(7'b1100000));

        // Asynchronous reset at digit 2, slot count 5; load during reset is ignored.
        seen = 1'b0;
        for (int k = 0; k < FRAME + 4 && !seen; k++) begin
            @(negedge clk);
            seen = (pos == 2 * DIV + 5);
        end
        check("reach_d2s5", 16'(seen), 16'd1);
        #1 reset = 1'b1;
        #1;
        check("async_an", 16'(an), 16'hF);
        check("async_seg", 16'(seg), 16'h7F);
        check("async_dp", 16'(dp), 16'd1);
        check("async_fd", 16'(frame_done), 16'd0);
        data_in = 16'hFFFF; dp_in = 4'hF; load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load = 1'b0;
        reset = 1'b0;
        check_startup();

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
